// File: rtl/priority_arbiter.sv
// rtl/priority_arbiter.sv - N-way arbiter with registered one-hot grants, hold-until-release,
// optional round-robin rotation and a hold-timeout watchdog.
module priority_arbiter #(
    parameter int N        = 8,
    parameter int IDW      = 3,
    parameter int RR       = 0,
    parameter int MAX_HOLD = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           timeout
);

    localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  hold_cnt, hold_cnt_nx;
    logic [IDW-1:0] last_id, last_id_nx;
    logic [IDW-1:0] grant_id_nx;
    logic [IDW-1:0] win, cand;
    logic [N-1:0]   mask, mask_nx;
    logic [N-1:0]   elig;
    logic [N-1:0]   grant_nx;
    logic           grant_valid_nx;
    logic           timeout_nx;
    logic           found;

    // Round-robin search walks downward from last_id-1 and tests last_id itself last,
    // so the requester just served drops to lowest priority.
    always_comb begin
        elig  = req & ~mask;
        win   = '0;
        cand  = '0;
        found = 1'b0;
        if (RR == 0) begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) win = IDW'(i);
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                cand = IDW'((int'(last_id) + N - k) % N);
                if (!found && elig[cand]) begin
                    win   = cand;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx       = state;
        grant_nx       = grant;
        grant_id_nx    = grant_id;
        grant_valid_nx = grant_valid;
        timeout_nx     = 1'b0;
        hold_cnt_nx    = hold_cnt;
        last_id_nx     = last_id;
        mask_nx        = mask & req;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nx       = GRANT;
                    grant_nx       = N'(1) << win;
                    grant_id_nx    = win;
                    grant_valid_nx = 1'b1;
                    hold_cnt_nx    = CW'(1);
                    last_id_nx     = win;
                end
            end
            GRANT: begin
                // A release on the limit cycle wins over the watchdog.
                if (!req[grant_id]) begin
                    state_nx       = IDLE;
                    grant_nx       = '0;
                    grant_id_nx    = '0;
                    grant_valid_nx = 1'b0;
                end else if (MAX_HOLD != 0 && hold_cnt == CW'(MAX_HOLD)) begin
                    state_nx          = IDLE;
                    grant_nx          = '0;
                    grant_id_nx       = '0;
                    grant_valid_nx    = 1'b0;
                    timeout_nx        = 1'b1;
                    mask_nx[grant_id] = 1'b1;
                end else if (MAX_HOLD != 0) begin
                    hold_cnt_nx = hold_cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt    <= '0;
            last_id     <= '0;
            mask        <= '0;
        end else begin
            state       <= state_nx;
            grant       <= grant_nx;
            grant_id    <= grant_id_nx;
            grant_valid <= grant_valid_nx;
            timeout     <= timeout_nx;
            hold_cnt    <= hold_cnt_nx;
            last_id     <= last_id_nx;
            mask        <= mask_nx;
        end
    end

endmodule

// File: tb/tb_priority_arbiter.sv
// tb/tb_priority_arbiter.sv - scoreboard bench for priority_arbiter: fixed priority with
// a 4-cycle watchdog on one instance, round-robin without watchdog on the other.
module tb_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req_a = '0;
    logic [7:0] req_b = '0;
    logic [7:0] grant_a, grant_b;
    logic [2:0] gid_a, gid_b;
    logic       gv_a, gv_b, to_a, to_b;
    logic [12:0] obs_a, obs_b;
    logic [12:0] sb [$];
    logic [12:0] e;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    priority_arbiter #(.N(8), .IDW(3), .RR(0), .MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .grant(grant_a),
        .grant_id(gid_a), .grant_valid(gv_a), .timeout(to_a)
    );

    priority_arbiter #(.N(8), .IDW(3), .RR(1), .MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .grant(grant_b),
        .grant_id(gid_b), .grant_valid(gv_b), .timeout(to_b)
    );

    assign obs_a = {grant_a, gid_a, gv_a, to_a};
    assign obs_b = {grant_b, gid_b, gv_b, to_b};

    // Expected observation from a one-hot grant: encoded id and valid derived here.
    function automatic logic [12:0] ex(input logic [7:0] g, input logic to);
        logic [2:0] id;
        id = '0;
        for (int i = 0; i < 8; i++) if (g[i]) id = i[2:0];
        return {g, id, |g, to};
    endfunction

    task automatic test_reset;
        @(negedge clk);
        sb.push_back(ex(8'h00, 1'b0));
        sb.push_back(ex(8'h00, 1'b0));
        e = sb.pop_front();
        vectors++;
        if (obs_a !== e) begin
            miscompares++;
            $display("FAIL reset_a: got %h want %h", obs_a, e);
        end
        e = sb.pop_front();
        vectors++;
        if (obs_b !== e) begin
            miscompares++;
            $display("FAIL reset_b: got %h want %h", obs_b, e);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle;
        for (int i = 0; i < 4; i++) begin
            req_a = 8'h00;
            sb.push_back(ex(8'h00, 1'b0));
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (obs_a !== e) begin
                miscompares++;
                $display("FAIL idle[%0d]: got %h want %h", i, obs_a, e);
            end
        end
    endtask

    task automatic test_fixed_priority;
        logic [7:0] r [7];
        logic [7:0] g [7];
        r = '{8'hA4, 8'hA4, 8'h24, 8'h24, 8'h24, 8'hA4, 8'h00};
        g = '{8'h80, 8'h80, 8'h00, 8'h20, 8'h20, 8'h20, 8'h00};
        for (int i = 0; i < 7; i++) begin
            req_a = r[i];
            sb.push_back(ex(g[i], 1'b0));
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (obs_a !== e) begin
                miscompares++;
                $display("FAIL fixed_priority[%0d]: got %h want %h", i, obs_a, e);
            end
        end
    endtask

    task automatic test_timeout;
        logic [7:0] r [10];
        logic [7:0] g [10];
        logic       t [10];
        r = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h00};
        g = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00};
        t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            req_a = r[i];
            sb.push_back(ex(g[i], t[i]));
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (obs_a !== e) begin
                miscompares++;
                $display("FAIL timeout[%0d]: got %h want %h", i, obs_a, e);
            end
        end
    endtask

    task automatic test_release_at_limit;
        logic [7:0] r [7];
        logic [7:0] g [7];
        r = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h00};
        g = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h08, 8'h00};
        for (int i = 0; i < 7; i++) begin
            req_a = r[i];
            sb.push_back(ex(g[i], 1'b0));
            @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (obs_a !== e) begin
                miscompares++;
                $display("FAIL release_at_limit[%0d]: got %h want %h", i, obs_a, e);
            end
        end
    endtask

    task automatic test_round_robin;
        int id;
        int holds;
        for (int i = 0; i < 9; i++) begin
            id    = (15 - i) % 8;
            holds = (i == 8) ? 70 : 2;
            for (int h = 0; h <= holds; h++) begin
                req_b = (h == holds) ? (8'hFF ^ (8'h01 << id)) : 8'hFF;
                sb.push_back(ex((h == holds) ? 8'h00 : (8'h01 << id), 1'b0));
                @(negedge clk);
                e = sb.pop_front();
                vectors++;
                if (obs_b !== e) begin
                    miscompares++;
                    $display("FAIL round_robin[%0d.%0d]: got %h want %h", i, h, obs_b, e);
                end
            end
        end
        req_b = 8'h00;
        sb.push_back(ex(8'h00, 1'b0));
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (obs_b !== e) begin
            miscompares++;
            $display("FAIL round_robin_end: got %h want %h", obs_b, e);
        end
    endtask

    task automatic test_reset_mid_grant;
        req_a = 8'h10;
        sb.push_back(ex(8'h10, 1'b0));
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (obs_a !== e) begin
            miscompares++;
            $display("FAIL mid_grant_pre: got %h want %h", obs_a, e);
        end
        #2;
        rst   = 1'b1;
        req_a = 8'h11;
        sb.push_back(ex(8'h00, 1'b0));
        #1;
        e = sb.pop_front();
        vectors++;
        if (obs_a !== e) begin
            miscompares++;
            $display("FAIL mid_grant_async_clear: got %h want %h", obs_a, e);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(ex(8'h10, 1'b0));
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (obs_a !== e) begin
            miscompares++;
            $display("FAIL mid_grant_post: got %h want %h", obs_a, e);
        end
        req_a = 8'h00;
        sb.push_back(ex(8'h00, 1'b0));
        @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (obs_a !== e) begin
            miscompares++;
            $display("FAIL mid_grant_release: got %h want %h", obs_a, e);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_fixed_priority();
        test_timeout();
        test_release_at_limit();
        test_round_robin();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
